// File: rtl/elastic_inv_buffer.sv
// Elastic valid/ready FIFO with a per-bit output polarity mask.
// Storage holds raw input words; the INVERT mask is applied on the read side.
// Pointers carry an extra wrap bit so full and empty are distinguished
// without a separate occupancy register.
module elastic_inv_buffer #(
    parameter int               WIDTH  = 8,
    parameter int               DEPTH  = 4,
    parameter logic [WIDTH-1:0] INVERT = '0,
    localparam int              AW     = $clog2(DEPTH),
    localparam int              CW     = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty,
    output logic             ovf
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             push;
    logic             pop;

    // Flags come purely from registered pointers, so in_ready never depends
    // combinationally on out_ready and a full buffer cannot refill in the
    // same cycle it is popped.
    always_comb begin
        full      = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        empty     = (wr_ptr == rd_ptr);
        count     = wr_ptr - rd_ptr;
        in_ready  = ~full;
        out_valid = ~empty;
        push      = in_valid & ~full;
        pop       = ~empty & out_ready;
        out_data  = mem[rd_ptr[AW-1:0]] ^ INVERT;
    end

    // Pointer and sticky overflow state; pointers wrap naturally modulo 2*DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (in_valid && full) begin
                ovf <= 1'b1;
            end
        end
    end

    // Storage array is deliberately left unreset; entries are only valid
    // between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end

endmodule
